// File: rtl/spi_pkg.sv
// Shared SPI definitions: transfer modes, engine states, default half-periods.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

    typedef enum logic [1:0] {
        SPI_MODE_WRITE    = 2'd0,
        SPI_MODE_READ     = 2'd1,
        SPI_MODE_EXCHANGE = 2'd2,
        SPI_MODE_WAITREAD = 2'd3
    } spi_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_STORE
    } spi_state_e;

    // 48 MHz / (2 * 60) = 400 kHz for TF card init; fast mode runs at FastClk / 2.
    localparam int SPI_SLOW_HALF_PERIOD = 60;
    localparam int SPI_FAST_HALF_PERIOD = 1;
    localparam int SPI_DIV_W            = 8;

    // Read-only modes clock out 0xFF instead of buffer contents.
    function automatic logic mode_ignores_tx(input spi_mode_e mode);
        return (mode == SPI_MODE_READ) || (mode == SPI_MODE_WAITREAD);
    endfunction

    // Every mode except plain write deposits received bytes in the RX buffer.
    function automatic logic mode_writes_rx(input spi_mode_e mode);
        return mode != SPI_MODE_WRITE;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider: emits a one-cycle tick every 'half' enabled FastClk cycles.
// Latency: first tick 'half' cycles after enable rises from a cleared count.
// Backpressure: none; count holds while enable is low, clear restarts it.
module spi_clk_div
    import spi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [SPI_DIV_W-1:0] half,
    output logic                 tick
);

    logic [SPI_DIV_W-1:0] cnt;

    assign tick = enable && (cnt == half - SPI_DIV_W'(1));

    // Count enabled cycles, wrapping to zero on each tick.
    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + SPI_DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// Byte-level SPI master: walks the TX buffer, shifts bytes MSB first, writes received bytes to RX.
// Latency: 1 + 16*H + 1 FastClk cycles per counted byte; Busy rises one cycle after Start.
// Backpressure: none; Start is ignored while busy, Abort returns to idle on the next cycle.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int SLOW_HALF_PERIOD = SPI_SLOW_HALF_PERIOD,
    parameter int FAST_HALF_PERIOD = SPI_FAST_HALF_PERIOD
) (
    input  logic       FastClk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Abort,
    input  logic [1:0] Mode,
    input  logic [8:0] Length,
    input  logic       SlowClk,
    output logic [8:0] TXAddr,
    input  logic [7:0] TXData,
    output logic [8:0] RXAddr,
    output logic [7:0] RXData,
    output logic       RXWrite,
    output logic       Busy,
    output logic       SPIClk,
    output logic       SPIDo,
    input  logic       SPIDi
);

    localparam logic [SPI_DIV_W-1:0] SLOW_H = SPI_DIV_W'(SLOW_HALF_PERIOD);
    localparam logic [SPI_DIV_W-1:0] FAST_H = SPI_DIV_W'(FAST_HALF_PERIOD);

    spi_state_e           state;
    spi_mode_e            mode_q;
    logic [8:0]           len_q;
    logic [SPI_DIV_W-1:0] half_q;
    logic [9:0]           byte_cnt;   // counted bytes; reaches 512 without wrapping
    logic [3:0]           edge_cnt;   // SPIClk edges within the current byte
    logic [6:0]           tx_sr;      // bits still to be shifted out after the MSB
    logic [7:0]           rx_sr;
    logic                 last_q;
    logic                 tick;
    logic                 div_en;
    logic                 div_clear;
    logic                 byte_keep;
    logic                 byte_last;
    logic [7:0]           load_byte;

    assign div_en    = (state == ST_SHIFT);
    assign div_clear = Abort || (state == ST_LOAD);
    assign load_byte = mode_ignores_tx(mode_q) ? 8'hFF : TXData;
    // Wait-and-read drops leading 0xFF bytes until the slave sends its first real byte.
    assign byte_keep = !((mode_q == SPI_MODE_WAITREAD) && (byte_cnt == 10'd0) && (rx_sr == 8'hFF));
    assign byte_last = (byte_cnt == {1'b0, len_q});

    spi_clk_div u_clk_div (
        .clk    (FastClk),
        .rst    (Reset),
        .clear  (div_clear),
        .enable (div_en),
        .half   (half_q),
        .tick   (tick)
    );

    // Transfer sequencer; TXAddr runs one cycle ahead of LOAD so synchronous-RAM data lands in LOAD.
    always_ff @(posedge FastClk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            mode_q   <= SPI_MODE_WRITE;
            len_q    <= '0;
            half_q   <= FAST_H;
            byte_cnt <= '0;
            edge_cnt <= '0;
            tx_sr    <= '1;
            rx_sr    <= '0;
            last_q   <= 1'b0;
            TXAddr   <= '0;
            RXAddr   <= '0;
            RXData   <= '0;
            RXWrite  <= 1'b0;
            Busy     <= 1'b0;
            SPIClk   <= 1'b0;
            SPIDo    <= 1'b1;
        end else if (Abort) begin
            state   <= ST_IDLE;
            TXAddr  <= '0;
            RXWrite <= 1'b0;
            Busy    <= 1'b0;
            SPIClk  <= 1'b0;
            SPIDo   <= 1'b1;
        end else begin
            RXWrite <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        mode_q   <= spi_mode_e'(Mode);
                        len_q    <= Length;
                        half_q   <= SlowClk ? SLOW_H : FAST_H;
                        byte_cnt <= '0;
                        TXAddr   <= '0;
                        Busy     <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tx_sr    <= load_byte[6:0];
                    SPIDo    <= load_byte[7];
                    edge_cnt <= '0;
                    state    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (tick) begin
                        edge_cnt <= edge_cnt + 4'd1;
                        if (!edge_cnt[0]) begin
                            SPIClk <= 1'b1;
                            rx_sr  <= {rx_sr[6:0], SPIDi};
                        end else begin
                            SPIClk <= 1'b0;
                            if (edge_cnt == 4'd15) begin
                                SPIDo  <= 1'b1;
                                last_q <= byte_keep && byte_last;
                                state  <= ST_STORE;
                                if (byte_keep) begin
                                    byte_cnt <= byte_cnt + 10'd1;
                                    if (!byte_last) begin
                                        TXAddr <= byte_cnt[8:0] + 9'd1;
                                    end
                                    if (mode_writes_rx(mode_q)) begin
                                        RXWrite <= 1'b1;
                                        RXAddr  <= byte_cnt[8:0];
                                        RXData  <= rx_sr;
                                    end
                                end
                            end else begin
                                SPIDo <= tx_sr[6];
                                tx_sr <= {tx_sr[5:0], 1'b1};
                            end
                        end
                    end
                end
                ST_STORE: begin
                    if (last_q) begin
                        state  <= ST_IDLE;
                        Busy   <= 1'b0;
                        TXAddr <= '0;
                    end else begin
                        state <= ST_LOAD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine with an SPI mode-0 slave model and RX/MOSI scoreboards.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_shift_engine;

    logic       FastClk = 1'b0;
    logic       Reset, Start, Abort, SlowClk, SPIDi;
    logic [1:0] Mode;
    logic [8:0] Length;
    logic [7:0] TXData;
    logic [8:0] TXAddr, RXAddr;
    logic [7:0] RXData;
    logic       RXWrite, Busy, SPIClk, SPIDo;

    int total  = 0;
    int passed = 0;

    typedef struct packed {
        logic [8:0] addr;
        logic [7:0] data;
    } rxw_t;

    logic [7:0] tx_mem [0:511];
    rxw_t       exp_rx[$];
    logic [7:0] exp_mosi[$];
    logic [7:0] slave_tx[$];

    int         gen = 0;
    int         gen_seen = 0;
    int         rxw_cnt, max_tx, wrap_cnt, hi_cnt, last_hi, s_bit, s_inbits;
    logic [7:0] s_out, s_in;
    logic       prev_clk;
    logic [8:0] prev_tx;
    int         cyc;

    spi_shift_engine dut (
        .FastClk (FastClk),
        .Reset   (Reset),
        .Start   (Start),
        .Abort   (Abort),
        .Mode    (Mode),
        .Length  (Length),
        .SlowClk (SlowClk),
        .TXAddr  (TXAddr),
        .TXData  (TXData),
        .RXAddr  (RXAddr),
        .RXData  (RXData),
        .RXWrite (RXWrite),
        .Busy    (Busy),
        .SPIClk  (SPIClk),
        .SPIDo   (SPIDo),
        .SPIDi   (SPIDi)
    );

    always #5 FastClk = ~FastClk;

    // TX buffer: synchronous read, data one cycle after the address.
    always @(posedge FastClk) TXData <= tx_mem[TXAddr];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_reset(input string p);
        check({p, "_spiclk"},  SPIClk,  0);
        check({p, "_spido"},   SPIDo,   1);
        check({p, "_busy"},    Busy,    0);
        check({p, "_rxwrite"}, RXWrite, 0);
        check({p, "_txaddr"},  TXAddr,  0);
        check({p, "_rxaddr"},  RXAddr,  0);
        check({p, "_rxdata"},  RXData,  0);
    endtask

    // Slave model + monitor: mode-0 slave, MOSI and RX write scoreboards, timing probes.
    always @(negedge FastClk) begin
        if (gen != gen_seen) begin
            gen_seen  = gen;
            s_bit     = 0;
            s_inbits  = 0;
            s_in      = 8'h00;
            s_out     = (slave_tx.size() > 0) ? slave_tx.pop_front() : 8'hFF;
            SPIDi     = s_out[7];
            prev_clk  = SPIClk;
            rxw_cnt   = 0;
            max_tx    = 0;
            wrap_cnt  = 0;
            hi_cnt    = 0;
            last_hi   = 0;
            prev_tx   = TXAddr;
        end else begin
            if (SPIClk && !prev_clk) begin
                s_in = {s_in[6:0], SPIDo};
                s_inbits++;
                if (s_inbits == 8) begin
                    s_inbits = 0;
                    if (exp_mosi.size() == 0) begin
                        total++;
                        $display("FAIL mosi_extra: slave got byte 0x%0h, expected none", s_in);
                    end else begin
                        check("mosi_byte", s_in, exp_mosi.pop_front());
                    end
                end
            end
            if (!SPIClk && prev_clk) begin
                last_hi = hi_cnt;
                hi_cnt  = 0;
                s_bit++;
                if (s_bit == 8) begin
                    s_bit = 0;
                    s_out = (slave_tx.size() > 0) ? slave_tx.pop_front() : 8'hFF;
                end else begin
                    s_out = {s_out[6:0], 1'b1};
                end
                SPIDi = s_out[7];
            end
            if (SPIClk) hi_cnt++;
            prev_clk = SPIClk;
            if (Busy) begin
                if (int'(TXAddr) > max_tx) max_tx = int'(TXAddr);
                if (TXAddr < prev_tx) wrap_cnt++;
            end
            prev_tx = TXAddr;
            if (RXWrite) begin
                rxw_cnt++;
                if (exp_rx.size() == 0) begin
                    total++;
                    $display("FAIL rx_extra: write addr %0d data 0x%0h, expected none", RXAddr, RXData);
                end else begin
                    rxw_t e;
                    e = exp_rx.pop_front();
                    check("rx_addr", RXAddr, e.addr);
                    check("rx_data", RXData, e.data);
                end
            end
        end
    end

    task automatic flush();
        exp_rx.delete();
        exp_mosi.delete();
        slave_tx.delete();
    endtask

    task automatic arm();
        gen++;
        @(negedge FastClk);
    endtask

    task automatic push_rx(input int a, input logic [7:0] d);
        rxw_t e;
        e.addr = a[8:0];
        e.data = d;
        exp_rx.push_back(e);
    endtask

    // Issue Start and count cycles until Busy drops; optionally pulse a stray Start at cycle 'poke'.
    task automatic run_xfer(input logic [1:0] m, input logic [8:0] len, input logic slow,
                            input int poke, output int n);
        @(posedge FastClk); #1;
        Mode = m; Length = len; SlowClk = slow; Start = 1'b1;
        @(posedge FastClk); #1;
        Start = 1'b0;
        n = 1;
        while (Busy && n < 20000) begin
            @(posedge FastClk); #1;
            n++;
            if (n == poke) begin
                Start = 1'b1; Mode = 2'd1; Length = 9'd9;
            end else begin
                Start = 1'b0;
            end
        end
        if (Busy) begin
            total++;
            $display("FAIL busy_timeout: still busy after %0d cycles", n);
        end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Abort = 1'b0; Mode = 2'd0; Length = 9'd0; SlowClk = 1'b0;
        for (int i = 0; i < 512; i++) tx_mem[i] = 8'h00;
        gen = 1;
        repeat (3) @(posedge FastClk);
        #1;
        check_reset("reset");
        Reset = 1'b0;

        // Exchange, fast, 4 bytes.
        tx_mem[0] = 8'hAB; tx_mem[1] = 8'hCD; tx_mem[2] = 8'hEF; tx_mem[3] = 8'h12;
        foreach (tx_mem[i]) if (i < 4) exp_mosi.push_back(tx_mem[i]);
        slave_tx.push_back(8'hFF); slave_tx.push_back(8'h3E);
        slave_tx.push_back(8'hCA); slave_tx.push_back(8'h04);
        push_rx(0, 8'hFF); push_rx(1, 8'h3E); push_rx(2, 8'hCA); push_rx(3, 8'h04);
        arm();
        run_xfer(2'd2, 9'd3, 1'b0, -1, cyc);
        check("xchg_cycles", cyc, 73);
        check("xchg_rxw", rxw_cnt, 4);
        check("xchg_rx_left", exp_rx.size(), 0);
        check("xchg_mosi_left", exp_mosi.size(), 0);

        // Wait-and-read, fast, 5 bytes after three leading 0xFF.
        flush();
        slave_tx.push_back(8'hFF); slave_tx.push_back(8'hFF); slave_tx.push_back(8'hFF);
        slave_tx.push_back(8'h53); slave_tx.push_back(8'h85); slave_tx.push_back(8'hF0);
        slave_tx.push_back(8'hFF); slave_tx.push_back(8'h21);
        for (int i = 0; i < 8; i++) exp_mosi.push_back(8'hFF);
        push_rx(0, 8'h53); push_rx(1, 8'h85); push_rx(2, 8'hF0); push_rx(3, 8'hFF); push_rx(4, 8'h21);
        arm();
        run_xfer(2'd3, 9'd4, 1'b0, -1, cyc);
        check("wr_cycles", cyc, 1 + 18 * 8);
        check("wr_rxw", rxw_cnt, 5);
        check("wr_rx_left", exp_rx.size(), 0);
        check("wr_mosi_left", exp_mosi.size(), 0);

        // Wait-and-read, slow, single byte after six 0xFF.
        flush();
        for (int i = 0; i < 6; i++) slave_tx.push_back(8'hFF);
        slave_tx.push_back(8'hE3);
        for (int i = 0; i < 7; i++) exp_mosi.push_back(8'hFF);
        push_rx(0, 8'hE3);
        arm();
        run_xfer(2'd3, 9'd0, 1'b1, -1, cyc);
        check("slow_cycles", cyc, 1 + 7 * (2 + 16 * 60));
        check("slow_half_period", last_hi, 60);
        check("slow_rxw", rxw_cnt, 1);
        check("slow_rx_left", exp_rx.size(), 0);

        // Write, fast, full 512-byte buffer.
        flush();
        for (int i = 0; i < 512; i++) begin
            tx_mem[i] = i[7:0];
            exp_mosi.push_back(i[7:0]);
        end
        arm();
        run_xfer(2'd0, 9'd511, 1'b0, -1, cyc);
        check("w512_cycles", cyc, 1 + 18 * 512);
        check("w512_rxw", rxw_cnt, 0);
        check("w512_max_txaddr", max_tx, 511);
        check("w512_no_wrap", wrap_cnt, 0);
        check("w512_mosi_left", exp_mosi.size(), 0);

        // Abort during SHIFT of byte 2 of a 4-byte read.
        flush();
        slave_tx.push_back(8'h11); slave_tx.push_back(8'h22);
        slave_tx.push_back(8'h33); slave_tx.push_back(8'h44);
        exp_mosi.push_back(8'hFF); exp_mosi.push_back(8'hFF);
        push_rx(0, 8'h11); push_rx(1, 8'h22);
        arm();
        @(posedge FastClk); #1;
        Mode = 2'd1; Length = 9'd3; SlowClk = 1'b0; Start = 1'b1;
        @(posedge FastClk); #1;
        Start = 1'b0;
        repeat (41) @(posedge FastClk);
        #1;
        Abort = 1'b1;
        @(posedge FastClk); #1;
        Abort = 1'b0;
        check("abort_busy", Busy, 0);
        check("abort_spiclk", SPIClk, 0);
        check("abort_spido", SPIDo, 1);
        check("abort_rxwrite", RXWrite, 0);
        repeat (3) @(posedge FastClk);
        #1;
        check("abort_rxw", rxw_cnt, 2);
        check("abort_rx_left", exp_rx.size(), 0);
        check("abort_mosi_left", exp_mosi.size(), 0);

        // Abort and Start together: Abort wins.
        Mode = 2'd2; Length = 9'd0; Start = 1'b1; Abort = 1'b1;
        @(posedge FastClk); #1;
        Start = 1'b0; Abort = 1'b0;
        check("abort_wins_busy", Busy, 0);

        // Normal transfer after abort.
        flush();
        tx_mem[0] = 8'h5A;
        slave_tx.push_back(8'hA5);
        exp_mosi.push_back(8'h5A);
        push_rx(0, 8'hA5);
        arm();
        run_xfer(2'd2, 9'd0, 1'b0, -1, cyc);
        check("post_abort_cycles", cyc, 19);
        check("post_abort_rxw", rxw_cnt, 1);
        check("post_abort_rx_left", exp_rx.size(), 0);

        // Start while busy is ignored.
        flush();
        tx_mem[0] = 8'h3C; tx_mem[1] = 8'hC3;
        exp_mosi.push_back(8'h3C); exp_mosi.push_back(8'hC3);
        arm();
        run_xfer(2'd0, 9'd1, 1'b0, 10, cyc);
        check("stray_start_cycles", cyc, 37);
        check("stray_start_rxw", rxw_cnt, 0);
        check("stray_start_mosi_left", exp_mosi.size(), 0);

        // Reset mid-transfer, after byte 0 has been written.
        flush();
        tx_mem[0] = 8'h99; tx_mem[1] = 8'h66; tx_mem[2] = 8'h0F;
        slave_tx.push_back(8'h77); slave_tx.push_back(8'h88); slave_tx.push_back(8'h99);
        exp_mosi.push_back(8'h99);
        push_rx(0, 8'h77);
        arm();
        @(posedge FastClk); #1;
        Mode = 2'd2; Length = 9'd2; SlowClk = 1'b0; Start = 1'b1;
        @(posedge FastClk); #1;
        Start = 1'b0;
        repeat (19) @(posedge FastClk);
        #1;
        check("midreset_rxdata_before", RXData, 8'h77);
        Reset = 1'b1;
        @(posedge FastClk); #1;
        Reset = 1'b0;
        check_reset("midreset");
        check("midreset_rx_left", exp_rx.size(), 0);
        check("midreset_mosi_left", exp_mosi.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
